// File: rtl/display_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg : glyph patterns, cell geometry, colours and FSM encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package display_pkg;

  // Seven-segment patterns, {a,b,c,d,e,f,g} with a in bit 6
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  // Unscaled cell and segment bounds
  localparam logic [10:0] CELL_W    = 11'd18;
  localparam logic [10:0] CELL_H    = 11'd42;
  localparam logic [10:0] SEG_EDGE  = 11'd3;
  localparam logic [10:0] SEG_INNER = 11'd15;
  localparam logic [10:0] SEG_G_TOP = 11'd19;
  localparam logic [10:0] SEG_MID   = 11'd21;
  localparam logic [10:0] SEG_G_BOT = 11'd23;
  localparam logic [10:0] SEG_BOT   = 11'd39;

  localparam logic [2:0] DEF_FG_R = 3'b111;
  localparam logic [2:0] DEF_FG_G = 3'b111;
  localparam logic [1:0] DEF_FG_B = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CONVERT = 2'd1;
  localparam state_t ST_DONE    = 2'd2;

  function automatic logic [6:0] digit_pattern(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // nx/ny are coordinates inside the normalised 18x42 cell
  function automatic logic seg_lit(input logic [6:0] pat, input logic [10:0] nx,
                                   input logic [10:0] ny);
    logic w_left, w_right, w_upper, w_lower;
    w_left  = nx < SEG_EDGE;
    w_right = nx > SEG_INNER;
    w_upper = (ny > SEG_EDGE) && (ny < SEG_MID);
    w_lower = (ny > SEG_MID) && (ny < SEG_BOT);
    return (pat[6] && (ny < SEG_EDGE))
        || (pat[5] && w_right && w_upper)
        || (pat[4] && w_right && w_lower)
        || (pat[3] && (ny > SEG_BOT))
        || (pat[2] && w_left && w_lower)
        || (pat[1] && w_left && w_upper)
        || (pat[0] && (nx > SEG_EDGE) && (nx < SEG_INNER)
                   && (ny > SEG_G_TOP) && (ny < SEG_G_BOT));
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq : sequential shift-add-3 binary to BCD converter, WIDTH cycles
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH  = 17,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_value,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_overflow
);

  localparam int                 C_CNT_W    = $clog2(WIDTH + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(WIDTH);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  logic [WIDTH-1:0]    r_shift;
  logic [4*DIGITS-1:0] r_bcd;
  logic [4*DIGITS-1:0] w_adj;
  logic [C_CNT_W-1:0]  r_count;
  logic                r_busy;
  logic                r_ovf;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_shift <= i_value;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_count <= C_CNT_INIT;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_bcd   <= {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
      r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      // A one leaving the top nibble means the value needs more digits
      r_ovf   <= r_ovf | w_adj[4*DIGITS-1];
      r_count <= r_count - C_CNT_ONE;
      if (r_count == C_CNT_ONE) r_busy <= 1'b0;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_count == C_CNT_ONE);
  assign o_bcd      = r_bcd;
  assign o_overflow = r_ovf;

endmodule

`default_nettype wire

// File: rtl/display_number.sv
// ----------------------------------------------------------------------------
// display_number : multi-digit scaled seven-segment renderer, tear-free commit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module display_number
  import display_pkg::*;
#(
  parameter int         XPOS        = 0,
  parameter int         YPOS        = 0,
  parameter int         WIDTH       = 17,
  parameter int         DIGITS      = 4,
  parameter int         SCALE_LOG2  = 0,
  parameter int         GAP         = 4,
  parameter int         BLANK_LZ    = 1,
  parameter int         COMMIT_LINE = 480,
  parameter logic [2:0] FG_R        = DEF_FG_R,
  parameter logic [2:0] FG_G        = DEF_FG_G,
  parameter logic [1:0] FG_B        = DEF_FG_B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       hc,
  input  logic [9:0]       vc,
  input  logic [WIDTH-1:0] value,
  input  logic             value_valid,
  output logic             value_ready,
  output logic [2:0]       red,
  output logic [2:0]       green,
  output logic [1:0]       blue,
  output logic             active
);

  localparam int          C_PITCH  = (18 << SCALE_LOG2) + GAP;
  localparam logic [10:0] C_CELL_W = CELL_W << SCALE_LOG2;
  localparam logic [10:0] C_TOP    = 11'(YPOS);
  localparam logic [10:0] C_BOT    = 11'(YPOS) + (CELL_H << SCALE_LOG2);
  localparam logic [9:0]  C_COMMIT = 10'(COMMIT_LINE);

  state_t              r_state;
  logic [4*DIGITS-1:0] r_disp_bcd;
  logic                r_disp_ovf;
  logic                r_disp_blank;
  logic                w_xfer;
  logic                w_conv_busy;
  logic                w_conv_done;
  logic [4*DIGITS-1:0] w_conv_bcd;
  logic                w_conv_ovf;
  logic [10:0]         w_hc11;
  logic [10:0]         w_vc11;
  logic                w_lit;
  logic [2:0]          r_red;
  logic [2:0]          r_green;
  logic [1:0]          r_blue;
  logic                r_active;

  assign value_ready = (r_state == ST_IDLE);
  assign w_xfer      = value_valid && value_ready;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_xfer && !w_conv_busy),
    .i_value    (value),
    .o_busy     (w_conv_busy),
    .o_done     (w_conv_done),
    .o_bcd      (w_conv_bcd),
    .o_overflow (w_conv_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_disp_bcd   <= '0;
      r_disp_ovf   <= 1'b0;
      r_disp_blank <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_xfer) r_state <= ST_CONVERT;
        ST_CONVERT: if (w_conv_done) r_state <= ST_DONE;
        ST_DONE: begin
          // Commit only at the frame boundary so a frame never mixes values
          if (vc == C_COMMIT && hc == 10'd0) begin
            r_disp_bcd   <= w_conv_bcd;
            r_disp_ovf   <= w_conv_ovf;
            r_disp_blank <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_hc11 = {1'b0, hc};
  assign w_vc11 = {1'b0, vc};

  always_comb begin
    logic        seen;
    logic [3:0]  nib;
    logic [6:0]  pat;
    logic [10:0] left;
    logic [10:0] dx;
    logic [10:0] dy;
    w_lit = 1'b0;
    seen  = 1'b0;
    nib   = '0;
    pat   = SEG_BLANK;
    left  = '0;
    dx    = '0;
    dy    = w_vc11 - C_TOP;
    for (int k = 0; k < DIGITS; k++) begin
      nib  = r_disp_bcd[4*(DIGITS-1-k) +: 4];
      seen = seen | (nib != 4'd0);
      left = 11'(XPOS + k * C_PITCH);
      dx   = w_hc11 - left;
      if (r_disp_blank)                                   pat = SEG_BLANK;
      else if (r_disp_ovf)                                pat = SEG_DASH;
      else if (BLANK_LZ != 0 && !seen && k != DIGITS - 1) pat = SEG_BLANK;
      else                                                pat = digit_pattern(nib);
      if (w_hc11 >= left && w_hc11 < left + C_CELL_W && w_vc11 >= C_TOP && w_vc11 < C_BOT)
        w_lit = w_lit | seg_lit(pat, dx >> SCALE_LOG2, dy >> SCALE_LOG2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_active <= 1'b0;
    end else begin
      r_red    <= w_lit ? FG_R : 3'd0;
      r_green  <= w_lit ? FG_G : 3'd0;
      r_blue   <= w_lit ? FG_B : 2'd0;
      r_active <= w_lit;
    end
  end

  assign red    = r_red;
  assign green  = r_green;
  assign blue   = r_blue;
  assign active = r_active;

endmodule

`default_nettype wire

// File: tb/tb_display_number.sv
// ----------------------------------------------------------------------------
// tb_display_number : directed scoreboard bench, two parameter sets side by side
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_display_number;

  localparam int W = 17;

  logic         clk;
  logic         rst_n;
  logic [9:0]   hc;
  logic [9:0]   vc;
  logic [W-1:0] value;
  logic         value_valid;
  logic         ready_a, ready_b;
  logic [2:0]   red_a, green_a, red_b, green_b;
  logic [1:0]   blue_a, blue_b;
  logic         active_a, active_b;

  int n_checks = 0;
  int n_pass   = 0;
  int shown_a  = -1;
  int shown_b  = -1;

  typedef struct {
    int         h;
    int         v;
    logic [8:0] ea;
    logic [8:0] eb;
  } exp_t;
  exp_t sb[$];

  display_number #(.XPOS(8), .YPOS(4), .WIDTH(W), .DIGITS(4), .SCALE_LOG2(0),
                   .GAP(4), .BLANK_LZ(1), .COMMIT_LINE(480)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .value(value),
    .value_valid(value_valid), .value_ready(ready_a),
    .red(red_a), .green(green_a), .blue(blue_a), .active(active_a));

  display_number #(.XPOS(100), .YPOS(2), .WIDTH(W), .DIGITS(4), .SCALE_LOG2(1),
                   .GAP(4), .BLANK_LZ(0), .COMMIT_LINE(480)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .value(value),
    .value_valid(value_valid), .value_ready(ready_b),
    .red(red_b), .green(green_b), .blue(blue_b), .active(active_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference renderer working from the decimal value, not from BCD
  function automatic bit model_lit(int shown, bit blz, int xpos, int ypos, int sl,
                                   int h, int v);
    int s, p, k, off, x, y, d;
    int pw[4];
    logic [6:0] pat;
    pw = '{1000, 100, 10, 1};
    s  = 1 << sl;
    p  = 18 * s + 4;
    if (shown < 0 || h < xpos || v < ypos || v >= ypos + 42 * s) return 1'b0;
    k   = (h - xpos) / p;
    off = (h - xpos) % p;
    if (k > 3 || off >= 18 * s) return 1'b0;
    x = off / s;
    y = (v - ypos) / s;
    if (shown > 9999) pat = 7'b0000001;
    else if (blz && k < 3 && shown < pw[k]) pat = 7'b0000000;
    else begin
      d = (shown / pw[k]) % 10;
      case (d)
        0: pat = 7'b1111110;  1: pat = 7'b0110000;  2: pat = 7'b1101101;
        3: pat = 7'b1111001;  4: pat = 7'b0110011;  5: pat = 7'b1011011;
        6: pat = 7'b1011111;  7: pat = 7'b1110000;  8: pat = 7'b1111111;
        default: pat = 7'b1111011;
      endcase
    end
    return (pat[6] && y < 3) || (pat[5] && x > 15 && y > 3 && y < 21)
        || (pat[4] && x > 15 && y > 21 && y < 39) || (pat[3] && y > 39)
        || (pat[2] && x < 3 && y > 21 && y < 39) || (pat[1] && x < 3 && y > 3 && y < 21)
        || (pat[0] && x > 3 && x < 15 && y > 19 && y < 23);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
  endtask

  task automatic px_core(input int h, input int v, input bit la, input bit lb);
    exp_t e;
    hc   = 10'(h);
    vc   = 10'(v);
    e.h  = h;
    e.v  = v;
    e.ea = la ? 9'h1FF : 9'h000;
    e.eb = lb ? 9'h1FF : 9'h000;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("pixA h=%0d v=%0d", e.h, e.v), {23'd0, active_a, red_a, green_a, blue_a}, {23'd0, e.ea});
      chk($sformatf("pixB h=%0d v=%0d", e.h, e.v), {23'd0, active_b, red_b, green_b, blue_b}, {23'd0, e.eb});
    end
  endtask

  task automatic px(input int h, input int v);
    px_core(h, v, model_lit(shown_a, 1'b1, 8, 4, 0, h, v),
                  model_lit(shown_b, 1'b0, 100, 2, 1, h, v));
  endtask

  task automatic scan(input int h0, input int h1, input int v0, input int v1, input int vstep);
    for (int v = v0; v <= v1; v += vstep)
      for (int h = h0; h <= h1; h++) px(h, v);
  endtask

  task automatic load(input int val);
    int n;
    hc = 10'd700;
    vc = 10'd500;
    n  = 0;
    while (!(ready_a && ready_b) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_load", {30'd0, ready_a, ready_b}, 32'd3);
    value       = W'(val);
    value_valid = 1'b1;
    @(posedge clk); #1;
    value_valid = 1'b0;
    chk("ready_low_after_accept", {30'd0, ready_a, ready_b}, 32'd0);
  endtask

  task automatic wait_busy(input int cycles);
    hc = 10'd700;
    vc = 10'd500;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk("ready_low_busy", {30'd0, ready_a, ready_b}, 32'd0);
    end
  endtask

  task automatic commit(input int val);
    px(0, 480);
    shown_a = val;
    shown_b = val;
    chk("ready_after_commit", {30'd0, ready_a, ready_b}, 32'd3);
  endtask

  initial begin
    rst_n       = 1'b0;
    hc          = '0;
    vc          = '0;
    value       = '0;
    value_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {14'd0, active_a, red_a, green_a, blue_a, active_b, red_b, green_b, blue_b}, 32'd0);
    chk("reset_ready", {30'd0, ready_a, ready_b}, 32'd3);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", {30'd0, ready_a, ready_b}, 32'd3);
    scan(0, 259, 0, 88, 4);

    // 1234 with an ignored valid pulse while busy, held until the boundary
    vc = 10'd100;
    load(1234);
    wait_busy(W + 1);
    value       = W'(9999);
    value_valid = 1'b1;
    wait_busy(3);
    value_valid = 1'b0;
    value       = W'(1234);
    scan(28, 50, 4, 8, 2);
    commit(1234);
    px_core(9, 4, 1'b0, 1'b0);
    px_core(31, 4, 1'b1, 1'b0);
    px_core(141, 4, 1'b0, 1'b1);
    px_core(141, 5, 1'b0, 1'b1);
    px_core(137, 20, 1'b0, 1'b0);
    scan(0, 259, 0, 88, 4);

    load(7);
    wait_busy(W + 1);
    commit(7);
    px_core(75, 4, 1'b1, 1'b0);
    px_core(53, 4, 1'b0, 1'b0);
    px_core(101, 2, 1'b0, 1'b1);
    scan(0, 259, 0, 88, 4);

    load(0);
    wait_busy(W + 1);
    commit(0);
    scan(0, 259, 0, 88, 4);

    // Boundary during conversion must not commit
    load(10000);
    px(0, 480);
    wait_busy(W);
    scan(70, 95, 4, 44, 4);
    commit(10000);
    px_core(10, 24, 1'b0, 1'b0);
    px_core(15, 24, 1'b1, 1'b0);
    px_core(15, 4, 1'b0, 1'b0);
    scan(0, 259, 0, 88, 4);

    // Reset in the middle of a conversion blanks the display
    load(555);
    wait_busy(5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    shown_a = -1;
    shown_b = -1;
    rst_n   = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midreset", {30'd0, ready_a, ready_b}, 32'd3);
    scan(0, 259, 0, 88, 4);
    load(42);
    wait_busy(W + 1);
    scan(70, 95, 4, 44, 8);
    commit(42);
    scan(0, 259, 0, 88, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
